// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus controllers: FSM state encoding,
// register-select constants, default bus timing and small sizing helpers.
package lcd_pkg;

    // Read/write engine phases of one bus cycle.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } lcd_state_t;

    // Register select values on LCD_RS.
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // Default bus timing in 50 MHz clock cycles, shared with the write side.
    localparam int T_AS_CYC      = 3;     // RS/RW setup before EN rises (>= 40 ns)
    localparam int T_EN_CYC      = 25;    // EN high time (>= 450 ns)
    localparam int T_HOLD_CYC    = 2;     // RS/RW hold after EN falls
    localparam int T_GAP_CYC     = 25;    // idle time so a full cycle is >= 1 us
    localparam int MAX_POLLS_DEF = 4000;  // busy-flag reads before a poll gives up

    // Position of the busy flag in a status read.
    localparam int BF_BIT = 7;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Largest of four cycle counts, used to size the shared phase timer.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter that times each bus phase. A load of N-1 makes the
// zero flag rise after N cycles; the count then rests at zero.
module lcd_cycle_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 8-bit bus read engine. Performs a single status (BF/AC) or data
// read, or polls the busy flag until it clears or a poll limit is reached.
// All bus strobes and results are registered.
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int T_AS      = T_AS_CYC,
    parameter int T_EN      = T_EN_CYC,
    parameter int T_HOLD    = T_HOLD_CYC,
    parameter int T_GAP     = T_GAP_CYC,
    parameter int MAX_POLLS = MAX_POLLS_DEF
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       oBusy,
    output logic       oDone,
    output logic [7:0] oData,
    output logic       oBF,
    output logic [6:0] oAC,
    output logic       oTimeout
);

    localparam int TW = cnt_width(max4(T_AS, T_EN, T_HOLD, T_GAP));
    localparam int PW = cnt_width(MAX_POLLS);

    localparam logic [TW-1:0] LD_AS   = TW'(T_AS - 1);
    localparam logic [TW-1:0] LD_EN   = TW'(T_EN - 1);
    localparam logic [TW-1:0] LD_HOLD = TW'(T_HOLD - 1);
    localparam logic [TW-1:0] LD_GAP  = TW'(T_GAP - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

    lcd_state_t    state;
    logic          rs_sel;       // read type latched at start
    logic          poll_mode;    // repeat status reads while BF=1
    logic [PW-1:0] poll_cnt;     // completed reads beyond the first
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_zero;
    logic          busy_again;   // last status read still busy
    logic          poll_more;    // another poll read is allowed

    assign busy_again = poll_mode && oBF;
    assign poll_more  = poll_cnt < POLL_LAST;

    lcd_cycle_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (iCLK),
        .rst_n     (iRST_N),
        .load      (timer_load),
        .load_value(timer_value),
        .zero      (timer_zero)
    );

    // Arm the phase timer on every transition into a timed phase.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    timer_load  = 1'b1;
                    timer_value = LD_AS;
                end
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = LD_EN;
                end
            end
            ST_EN_HI: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = LD_GAP;
                end
            end
            ST_GAP: begin
                if (timer_zero && busy_again && poll_more) begin
                    timer_load  = 1'b1;
                    timer_value = LD_AS;
                end
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = '0;
            end
        endcase
    end

    // Read-cycle sequencer with registered bus strobes and results.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_IDLE;
            rs_sel    <= RS_CMD;
            poll_mode <= 1'b0;
            poll_cnt  <= '0;
            LCD_RS    <= 1'b0;
            LCD_RW    <= 1'b0;
            LCD_EN    <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oData     <= 8'h00;
            oBF       <= 1'b0;
            oAC       <= 7'h00;
            oTimeout  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        rs_sel    <= iRS;
                        poll_mode <= iPoll & ~iRS;
                        poll_cnt  <= '0;
                        oTimeout  <= 1'b0;
                        oBusy     <= 1'b1;
                        LCD_RS    <= iRS;
                        LCD_RW    <= 1'b1;
                        LCD_EN    <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_zero) begin
                        LCD_EN <= 1'b1;
                        state  <= ST_EN_HI;
                    end
                end
                ST_EN_HI: begin
                    // Bus is sampled on the last EN-high cycle, when it is settled.
                    if (timer_zero) begin
                        if (rs_sel == RS_DATA) begin
                            oData <= LCD_DATA_IN;
                        end else begin
                            oBF <= LCD_DATA_IN[BF_BIT];
                            oAC <= LCD_DATA_IN[6:0];
                        end
                        LCD_EN <= 1'b0;
                        state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timer_zero) begin
                        LCD_RW <= 1'b0;
                        LCD_RS <= 1'b0;
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_zero) begin
                        if (busy_again && poll_more) begin
                            poll_cnt <= poll_cnt + PW'(1);
                            LCD_RS   <= rs_sel;
                            LCD_RW   <= 1'b1;
                            state    <= ST_SETUP;
                        end else begin
                            if (busy_again) begin
                                oTimeout <= 1'b1;
                            end
                            oBusy <= 1'b0;
                            oDone <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader: directed cases plus randomized
// reads and polls, checked against a transaction-level reference model.
module tb_lcd_bus_reader;

    localparam int TAS      = 3;
    localparam int TEN      = 25;
    localparam int THOLD    = 2;
    localparam int TGAP     = 25;
    localparam int MAXP     = 5;
    localparam int READ_LEN = TAS + TEN + THOLD + TGAP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rs = 1'b0;
    logic       poll = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic       busy, done, bf, timeout;
    logic [7:0] data;
    logic [6:0] ac;

    always #5 clk = ~clk;

    lcd_bus_reader #(
        .T_AS(TAS), .T_EN(TEN), .T_HOLD(THOLD), .T_GAP(TGAP), .MAX_POLLS(MAXP)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iRS(rs), .iPoll(poll),
        .LCD_DATA_IN(data_in), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
        .oBusy(busy), .oDone(done), .oData(data), .oBF(bf), .oAC(ac),
        .oTimeout(timeout)
    );

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Reference model state: results the LCD should have returned so far.
    logic [7:0] exp_data = 8'h00;
    logic       exp_bf = 1'b0;
    logic [6:0] exp_ac = 7'h00;
    logic       exp_rs = 1'b0;

    // Bytes the simulated LCD presents on successive EN pulses (last repeats).
    logic [7:0] bus_seq [8];
    int         bus_len = 1;

    // Bus monitor bookkeeping.
    int   en_rises = 0;
    int   en_len = 0;
    int   rw_run = 0;
    logic en_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seq_at(input int i);
        return bus_seq[(i < bus_len) ? i : bus_len - 1];
    endfunction

    // Watch the strobes: RW setup before EN, EN width, RS/RW stable across EN.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            en_prev = 1'b0;
            en_len  = 0;
            rw_run  = 0;
        end else begin
            if (lcd_en) check("rw_during_en", lcd_rw, 1'b1);
            if (lcd_en && !en_prev) begin
                en_rises++;
                data_in = seq_at(en_rises - 1);
                check("rw_setup_before_en", rw_run >= TAS, 1'b1);
                check("rs_at_en", lcd_rs, exp_rs);
                en_len = 0;
            end
            if (!lcd_en && en_prev) begin
                check("en_width", en_len, TEN);
                check("rs_in_hold", lcd_rs, exp_rs);
                check("rw_in_hold", lcd_rw, 1'b1);
            end
            if (lcd_en) en_len++;
            rw_run  = lcd_rw ? rw_run + 1 : 0;
            en_prev = lcd_en;
        end
    end

    // One request; model predicts read count, latency and final results.
    task automatic do_txn(input logic t_rs, input logic t_poll, input bit inject);
        int         reads;
        int         cycles;
        bit         exp_to;
        logic [7:0] b;
        reads  = 1;
        exp_to = 1'b0;
        if (t_poll && !t_rs) begin
            reads  = MAXP;
            exp_to = 1'b1;
            for (int i = 0; i < MAXP; i++) begin
                b = seq_at(i);
                if (!b[7]) begin
                    reads  = i + 1;
                    exp_to = 1'b0;
                    break;
                end
            end
        end
        b = seq_at(reads - 1);
        if (t_rs) exp_data = b;
        else begin
            exp_bf = b[7];
            exp_ac = b[6:0];
        end
        exp_rs = t_rs;

        @(negedge clk);
        en_rises = 0;
        data_in  = seq_at(0);
        start = 1'b1;
        rs    = t_rs;
        poll  = t_poll;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 1;
        check("busy_on_accept", busy, 1'b1);
        check("timeout_cleared", timeout, 1'b0);
        while (!done && cycles < reads * READ_LEN + 20) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (inject && cycles == 40) ? 1'b1 : 1'b0;
        end
        check("done_seen", done, 1'b1);
        check("latency", cycles, reads * READ_LEN + 1);
        check("en_pulses", en_rises, reads);
        check("data", data, exp_data);
        check("bf", bf, exp_bf);
        check("ac", ac, exp_ac);
        check("timeout", timeout, exp_to);
        check("busy_in_done", busy, 1'b0);
        if (inject) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        txn_no++;
        $display("txn %0d rs=%0d poll=%0d reads=%0d cycles=%0d data=%02h bf=%0d ac=%02h timeout=%0d",
                 txn_no, t_rs, t_poll, reads, cycles, data, bf, ac, timeout);
    endtask

    // Pull reset low in the middle of EN high and check everything clears.
    task automatic reset_mid_read();
        int k;
        bus_seq[0] = 8'h85;
        bus_len    = 1;
        exp_rs     = 1'b0;
        @(negedge clk);
        en_rises = 0;
        data_in  = seq_at(0);
        start = 1'b1;
        rs    = 1'b0;
        poll  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!lcd_en && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("en_reached", lcd_en, 1'b1);
        repeat (10) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        exp_data = 8'h00;
        exp_bf   = 1'b0;
        exp_ac   = 7'h00;
        check("rst_en", lcd_en, 1'b0);
        check("rst_rw", lcd_rw, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bf", bf, exp_bf);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_no_done", done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        txn_no++;
        $display("txn %0d reset during EN high", txn_no);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int nb;
        for (int i = 0; i < 8; i++) bus_seq[i] = 8'h00;
        #12;
        check("reset_rs", lcd_rs, 1'b0);
        check("reset_rw", lcd_rw, 1'b0);
        check("reset_en", lcd_en, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_data", data, 8'h00);
        check("reset_bfac", {bf, ac}, 8'h00);
        check("reset_timeout", timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Status read, then data read.
        bus_seq[0] = 8'h85; bus_len = 1;
        do_txn(1'b0, 1'b0, 1'b0);
        bus_seq[0] = 8'h41; bus_len = 1;
        do_txn(1'b1, 1'b0, 1'b0);
        // Poll: busy for three reads then ready.
        bus_seq[0] = 8'h80; bus_seq[1] = 8'h80; bus_seq[2] = 8'h80; bus_seq[3] = 8'h00;
        bus_len = 4;
        do_txn(1'b0, 1'b1, 1'b0);
        // Poll stuck busy: timeout, then the next request clears it.
        bus_seq[0] = 8'hFF; bus_len = 1;
        do_txn(1'b0, 1'b1, 1'b0);
        bus_seq[0] = 8'h2A; bus_len = 1;
        do_txn(1'b0, 1'b0, 1'b0);
        // Starts during GAP and DONE ignored; next-cycle start accepted.
        bus_seq[0] = 8'h13; bus_len = 1;
        do_txn(1'b0, 1'b0, 1'b1);
        bus_seq[0] = 8'h5A; bus_len = 1;
        do_txn(1'b1, 1'b0, 1'b0);
        // Asynchronous reset mid-read, then a fresh read.
        reset_mid_read();
        bus_seq[0] = 8'h07; bus_len = 1;
        do_txn(1'b0, 1'b0, 1'b0);

        // Randomized mix of status reads, data reads and polls.
        for (int n = 0; n < 20; n++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                bus_seq[0] = 8'($urandom); bus_len = 1;
                do_txn(1'b0, 1'b0, 1'b0);
            end else if (kind == 1) begin
                bus_seq[0] = 8'($urandom); bus_len = 1;
                do_txn(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                nb = $urandom_range(0, 6);
                for (int i = 0; i < nb; i++) bus_seq[i] = 8'h80 | 8'($urandom_range(0, 127));
                bus_seq[nb] = 8'($urandom_range(0, 127));
                bus_len = nb + 1;
                do_txn(1'b0, 1'b1, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_reader.md
Name: lcd_bus_reader

Overview:
HD44780 8-bit bus read engine, the read-side counterpart of the LCD write controller. It performs single read cycles: a busy-flag/address read (RS=0, RW=1) or a DDRAM/CGRAM data read (RS=1, RW=1). It can also poll the busy flag until it clears, with a timeout, so the top level can gate writes on real LCD readiness and read back displayed text. It sits beside the write controller in the LCD top level on the 50 MHz clock. The top level muxes LCD_RS/LCD_EN/LCD_RW and tri-states LCD_DATA whenever LCD_RW=1.

Parameters:
T_AS, 3, cycles RS/RW stable before EN rises (≥40 ns at 50 MHz)
T_EN, 25, cycles EN held high (≥450 ns)
T_HOLD, 2, cycles RS/RW held after EN falls
T_GAP, 25, cycles idle after each read before the next EN may rise (cycle ≥1 µs)
MAX_POLLS, 4000, busy-flag reads allowed before a poll is abandoned

Ports:
iCLK  in  1  system clock, 50 MHz
iRST_N  in  1  asynchronous active-low reset
iStart  in  1  request pulse; sampled only in IDLE
iRS  in  1  read type: 0 = busy flag + address counter, 1 = data register
iPoll  in  1  with iRS=0: repeat reads until BF=0; ignored when iRS=1
LCD_DATA_IN  in  8  LCD data bus input, read side of the tri-state pad
LCD_RS  out  1  register select
LCD_RW  out  1  1 during a read cycle; the top level releases its data driver on this signal
LCD_EN  out  1  enable strobe
oBusy  out  1  high from the accepted iStart to the oDone cycle
oDone  out  1  one-cycle completion pulse
oData  out  8  last data-register byte read
oBF  out  1  last busy flag read
oAC  out  7  last address counter read
oTimeout  out  1  set with oDone when a poll exhausts MAX_POLLS; cleared on the next accepted iStart

Behaviour:
- Reset (asynchronous, iRST_N=0): every output is 0; FSM returns to IDLE; all counters are 0. This applies mid-cycle as well: EN drops immediately and no oDone is issued.
- FSM states: IDLE, SETUP, EN_HI, HOLD, GAP, DONE. One shared down-counter sized for the largest T_*.
- IDLE, iStart=1: latch iRS and poll mode (iPoll & ~iRS); clear oTimeout and the poll count; set oBusy; go to SETUP.
- SETUP (T_AS cycles): LCD_RS = latched iRS, LCD_RW=1, LCD_EN=0.
- EN_HI (T_EN cycles): LCD_EN=1. On the final EN_HI cycle, register LCD_DATA_IN:
  - RS=1: oData <= bus.
  - RS=0: oBF <= bus[7], oAC <= bus[6:0].
- HOLD (T_HOLD cycles): LCD_EN=0; RS and RW unchanged.
- GAP (T_GAP cycles): LCD_RW=0, LCD_RS=0.
- End of GAP:
  - Poll mode, BF=1, poll count < MAX_POLLS-1: increment the poll count and return to SETUP.
  - Poll mode, BF=1, poll count = MAX_POLLS-1: set oTimeout and go to DONE.
  - All other cases: go to DONE.
- DONE (1 cycle): oDone=1, oBusy=0, then IDLE.
- Latency of a single read, from the accepted iStart to oDone: T_AS+T_EN+T_HOLD+T_GAP+1 cycles, i.e. 56 at defaults.
- iStart while busy is ignored (not queued). iStart asserted in the DONE cycle is ignored; it is accepted one cycle later in IDLE.
- LCD_EN never rises unless LCD_RW=1 has been stable for ≥T_AS cycles. LCD_RW never falls while LCD_EN=1.
- Result registers (oData, oBF, oAC) hold their value until the next sample of the same type.
- The poll count is an integer wide enough for MAX_POLLS and does not wrap.

Decomposition:
- Shared package lcd_pkg:
  - state encoding;
  - RS constants RS_CMD=0, RS_DATA=1;
  - default timing cycle counts;
  - BF bit index 7.
  The same timing constants are used by the write controller.
- One natural sub-module: lcd_cycle_timer, a loadable down-counter with a zero flag, instantiated once.

Test Plan:
- Single busy read with bus held at 8'h85 → RW rises 3 cycles before EN; EN high 25 cycles; oDone at cycle 56; oBF=1, oAC=7'h05; oData unchanged.
- Data read with bus at 8'h41 ('A'), iRS=1 → oData=8'h41 at oDone; LCD_RS=1 throughout SETUP..HOLD; oBF and oAC unchanged.
- Poll with bus 8'h80 for 3 reads, then 8'h00 → exactly 4 EN pulses; oBF=0, oTimeout=0, oDone once.
- Poll with bus stuck at 8'hFF, MAX_POLLS=5 → 5 EN pulses, then oDone with oTimeout=1. The next iStart clears oTimeout.
- iRST_N pulled low in the middle of EN_HI → LCD_EN, LCD_RW and oBusy are 0 asynchronously; no oDone; a fresh iStart after reset completes normally.
- iStart pulsed during GAP and again in the DONE cycle → both ignored; an iStart one cycle after DONE is accepted.
